// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" id and the
// fetch FSM state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    BYTE0,
    REGS,
    CONST,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_len_dec.sv
// Combinational instruction-length decode from icode: total byte count and
// which optional parts (register byte, 8-byte constant) follow byte 0.
module fetch_len_dec
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       has_regs_o,
  output logic       has_const_o,
  output logic       valid_o
);

  always_comb begin
    len_o       = 4'd1;
    has_regs_o  = 1'b0;
    has_const_o = 1'b0;
    valid_o     = 1'b1;
    case (icode_i)
      I_HALT, I_NOP, I_RET: len_o = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        len_o      = 4'd2;
        has_regs_o = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len_o       = 4'd10;
        has_regs_o  = 1'b1;
        has_const_o = 1'b1;
      end
      I_JXX, I_CALL: begin
        len_o       = 4'd9;
        has_const_o = 1'b1;
      end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: reads an instruction byte-by-byte over a req/ack memory
// port and presents decoded fields, valP and error flags with a done pulse.
module fetch_unit
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              busy,
  output logic              done,
  output logic              instr_invalid,
  output logic              imem_error
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        idx_q, idx_d;
  logic [2:0]        cbyte_q, cbyte_d;
  logic              has_const_q, has_const_d;
  logic [3:0]        icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d, rb_q, rb_d;
  logic [63:0]       valc_q, valc_d;
  logic [ADDR_W-1:0] valp_q, valp_d;
  logic              inv_q, inv_d, err_q, err_d;

  logic [3:0] dec_len;
  logic       dec_regs, dec_const, dec_valid;

  // Decode straight from the incoming byte so the next state is known on the
  // same edge that captures byte 0.
  fetch_len_dec u_len_dec (
    .icode_i    (mem_rdata[7:4]),
    .len_o      (dec_len),
    .has_regs_o (dec_regs),
    .has_const_o(dec_const),
    .valid_o    (dec_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    idx_d       = idx_q;
    cbyte_d     = cbyte_q;
    has_const_d = has_const_q;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    valp_d      = valp_q;
    inv_d       = inv_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = BYTE0;
          pc_d        = pc_in;
          idx_d       = '0;
          cbyte_d     = '0;
          has_const_d = 1'b0;
          icode_d     = '0;
          ifun_d      = '0;
          ra_d        = RNONE;
          rb_d        = RNONE;
          valc_d      = '0;
          valp_d      = '0;
          inv_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
      BYTE0: begin
        if (mem_ack) begin
          if (mem_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            icode_d     = mem_rdata[7:4];
            ifun_d      = mem_rdata[3:0];
            valp_d      = pc_q + ADDR_W'(dec_len);
            has_const_d = dec_const;
            idx_d       = 4'd1;
            if (!dec_valid) begin
              inv_d   = 1'b1;
              state_d = DONE;
            end else if (dec_regs) begin
              state_d = REGS;
            end else if (dec_const) begin
              state_d = CONST;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      REGS: begin
        if (mem_ack) begin
          if (mem_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            ra_d    = mem_rdata[7:4];
            rb_d    = mem_rdata[3:0];
            idx_d   = idx_q + 4'd1;
            state_d = has_const_q ? CONST : DONE;
          end
        end
      end
      CONST: begin
        if (mem_ack) begin
          if (mem_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            valc_d[{cbyte_q, 3'b000} +: 8] = mem_rdata;
            idx_d   = idx_q + 4'd1;
            cbyte_d = cbyte_q + 3'd1;
            if (cbyte_q == 3'd7) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      idx_q       <= '0;
      cbyte_q     <= '0;
      has_const_q <= 1'b0;
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      valc_q      <= '0;
      valp_q      <= '0;
      inv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      cbyte_q     <= cbyte_d;
      has_const_q <= has_const_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      valp_q      <= valp_d;
      inv_q       <= inv_d;
      err_q       <= err_d;
    end
  end

  assign mem_req       = (state_q == BYTE0) || (state_q == REGS) || (state_q == CONST);
  assign busy          = mem_req;
  assign done          = (state_q == DONE);
  assign mem_addr      = pc_q + ADDR_W'(idx_q);
  assign icode         = icode_q;
  assign ifun          = ifun_q;
  assign rA            = ra_q;
  assign rB            = rb_q;
  assign valC          = valc_q;
  assign valP          = valp_q;
  assign instr_invalid = inv_q;
  assign imem_error    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of instruction fetches plus
// hand-written sequences for wait states, memory errors, reset and start filtering.
module tb_fetch_unit;

  logic        clk, rst_n, start;
  logic [63:0] pc_in;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack, mem_err;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        busy, done, instr_invalid, imem_error;

  fetch_unit #(.ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .busy(busy), .done(done), .instr_invalid(instr_invalid), .imem_error(imem_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory image and responder
  logic [7:0]  img [16];
  logic [63:0] img_base = 64'h0;
  int          ack_delay = 0;
  bit          err_en = 1'b0;
  logic [63:0] err_addr = 64'h0;
  int          n_acc = 0;
  int          req_cycles = 0;
  int          stab_err = 0;

  function automatic logic [7:0] lookup(input logic [63:0] a);
    logic [63:0] off;
    off = a - img_base;
    if (off < 64'd16) return img[off[3:0]];
    return 8'h00;
  endfunction

  initial begin
    int          wait_cnt;
    logic [63:0] held;
    wait_cnt = 0;
    held = '0;
    mem_ack = 1'b0; mem_rdata = 8'h00; mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (wait_cnt == 0) held = mem_addr;
        else if (mem_addr !== held) stab_err++;
        if (wait_cnt < ack_delay) begin
          mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 8'hXX;
          wait_cnt++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = lookup(mem_addr);
          mem_err   = err_en && (mem_addr == err_addr);
          n_acc++;
          wait_cnt = 0;
        end
      end else begin
        mem_ack = 1'b0; mem_err = 1'b0; wait_cnt = 0;
      end
    end
  end

  task automatic load(input logic [63:0] base, input logic [79:0] bytes);
    img_base = base;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    for (int i = 0; i < 10; i++) img[i] = bytes[79-8*i -: 8];
  endtask

  // Start on a negedge; count negedges after the start-sampling edge until done.
  task automatic run_fetch(input logic [63:0] pc, output int edges);
    n_acc = 0;
    @(negedge clk);
    start = 1'b1; pc_in = pc;
    @(negedge clk);
    start = 1'b0; pc_in = 64'h0;
    edges = 1;
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [79:0] bytes;
    int          n;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        inv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int   edges;
    int   acc0, req0;
    vec_t v;

    vecs.push_back('{"irmovq",  64'h100, 80'h30F3_0807060504030201, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h10A, 1'b0});
    vecs.push_back('{"jxx",     64'h20,  80'h7000_0100000000000000, 9,  4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 1'b0});
    vecs.push_back('{"halt",    64'h40,  80'h0000_0000000000000000, 1,  4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1'b0});
    vecs.push_back('{"opq",     64'h200, 80'h6102_0000000000000000, 2,  4'h6, 4'h1, 4'h0, 4'h2, 64'h0, 64'h202, 1'b0});
    vecs.push_back('{"invalid", 64'h300, 80'hC0FF_FFFFFFFFFFFFFFFF, 1,  4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 1'b1});
    vecs.push_back('{"ret_wrap",64'hFFFF_FFFF_FFFF_FFFF, 80'h9000_0000000000000000, 1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0});
    vecs.push_back('{"call",    64'h1000,80'h80EF_BEADDE00000000AA, 9,  4'h8, 4'h0, 4'hF, 4'hF, 64'h00000000DEADBEEF, 64'h1009, 1'b0});
    vecs.push_back('{"mrmov_wr",64'hFFFF_FFFF_FFFF_FFFC, 80'h5012_1000000000000000, 10, 4'h5, 4'h0, 4'h1, 4'h2, 64'h10, 64'h6, 1'b0});

    rst_n = 1'b1; start = 1'b0; pc_in = 64'h0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valP", valP, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fields", {icode, ifun, rA, rB}, 0);
    chk("rst_valC", valC, 0);
    chk("rst_flags", {instr_invalid, imem_error}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_req_before_start", req_cycles, 0);

    foreach (vecs[k]) begin
      v = vecs[k];
      load(v.pc, v.bytes);
      run_fetch(v.pc, edges);
      chk({v.name, "_done_edges"}, edges, v.n + 1);
      chk({v.name, "_icode"}, icode, v.icode);
      chk({v.name, "_ifun"}, ifun, v.ifun);
      chk({v.name, "_rA"}, rA, v.ra);
      chk({v.name, "_rB"}, rB, v.rb);
      chk({v.name, "_valC"}, valC, v.valc);
      chk({v.name, "_valP"}, valP, v.valp);
      chk({v.name, "_invalid"}, instr_invalid, v.inv);
      chk({v.name, "_imem_err"}, imem_error, 0);
      chk({v.name, "_busy_at_done"}, busy, 0);
      chk({v.name, "_accesses"}, n_acc, v.n);
    end

    // Wait states: three idle cycles before each ack.
    ack_delay = 3;
    load(64'h80, 80'h6001_0000000000000000);
    stab_err = 0;
    run_fetch(64'h80, edges);
    chk("wait_done_edges", edges, 2*4 + 1);
    chk("wait_addr_stable", stab_err, 0);
    chk("wait_rA", rA, 4'h0);
    chk("wait_rB", rB, 4'h1);
    chk("wait_valP", valP, 64'h82);
    repeat (2) @(negedge clk);
    chk("hold_valP_after_done", valP, 64'h82);
    chk("hold_rB_after_done", rB, 4'h1);
    ack_delay = 0;

    // Memory error on byte 3 of irmovq.
    load(64'h100, 80'h30F3_0807060504030201);
    err_en = 1'b1; err_addr = 64'h103;
    run_fetch(64'h100, edges);
    chk("err_done_edges", edges, 5);
    chk("err_flag", imem_error, 1);
    chk("err_accesses", n_acc, 4);
    req0 = req_cycles;
    repeat (4) @(negedge clk);
    chk("err_no_more_req", req_cycles, req0);
    err_en = 1'b0;

    // Start while busy and during the done cycle must be ignored.
    load(64'h100, 80'h30F3_0807060504030201);
    n_acc = 0;
    @(negedge clk); start = 1'b1; pc_in = 64'h100;
    @(negedge clk); pc_in = 64'h500;
    @(negedge clk); start = 1'b0;
    edges = 2;
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    chk("busy_start_edges", edges, 11);
    chk("busy_start_valP", valP, 64'h10A);
    chk("flags_cleared", {instr_invalid, imem_error}, 0);
    start = 1'b1; pc_in = 64'h700;
    @(negedge clk); start = 1'b0;
    acc0 = n_acc;
    chk("done_start_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_start_no_req", n_acc, acc0);
    chk("done_start_valP", valP, 64'h10A);

    // Asynchronous reset in the middle of the constant bytes.
    @(negedge clk); start = 1'b1; pc_in = 64'h100;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valP", valP, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    req0 = req_cycles;
    repeat (4) @(negedge clk);
    chk("post_rst_no_req", req_cycles, req0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
